// File: rtl/sd_stp_deser.sv
// Purpose : multi-lane serial-to-parallel deserialiser framing WORD_BITS words for the SD data path.
// Latency : completed word appears in word_data/word_valid the cycle after the completing shift.
// Backpr. : shift register never stalls; a word completing into a full holding register is dropped and sets overrun.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   clear               synchronous clear of partial word, holding register, overrun and CRC
//   shift_enable        shift serial_in (NUM_LANES bits, [NUM_LANES-1] = DAT3) into the shift register
//   parallel_out        live shift register, bit_count = beats received in the current word
//   word_data/_valid    completed word holding register, consumed with word_ready
//   overrun             sticky lost-word flag
//   crc_out             per-lane CRC16-CCITT, lane i at [16*i+15:16*i]
//
// Optional feature: define SD_STP_CRC16_EN to build the per-lane CRC16 checkers;
// otherwise crc_out is tied to zero with the same port list.
module sd_stp_deser #(
  parameter int WORD_BITS = 8,
  parameter int NUM_LANES = 1,
  parameter int SHIFT_MSB = 1,
  localparam int BEATS = WORD_BITS / NUM_LANES,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      shift_enable,
  input  logic [NUM_LANES-1:0]      serial_in,
  output logic [WORD_BITS-1:0]      parallel_out,
  output logic [CW-1:0]             bit_count,
  output logic [WORD_BITS-1:0]      word_data,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic                      overrun,
  output logic [16*NUM_LANES-1:0]   crc_out
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [WORD_BITS-1:0] sr_q, sr_d, sr_shift;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_BITS-1:0] wd_q, wd_d;
  logic                 wv_q, wv_d;
  logic                 ov_q, ov_d;
  logic                 complete;
  logic                 accept;

  // Shift direction is fixed at elaboration time.
  if (SHIFT_MSB != 0) begin : g_msb_first
    assign sr_shift = {sr_q[WORD_BITS-NUM_LANES-1:0], serial_in};
  end else begin : g_lsb_first
    assign sr_shift = {serial_in, sr_q[WORD_BITS-1:NUM_LANES]};
  end

  assign complete = shift_enable && (cnt_q == LAST_BEAT);
  assign accept   = wv_q && word_ready;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    wd_d  = wd_q;
    wv_d  = wv_q;
    ov_d  = ov_q;

    if (shift_enable) begin
      sr_d  = sr_shift;
      cnt_d = complete ? '0 : cnt_q + CW'(1);
    end

    // A word completing in the same cycle the old one is taken replaces it
    // without a bubble; only a completion into an untaken full slot is lost.
    if (complete && (!wv_q || accept)) begin
      wd_d = sr_shift;
      wv_d = 1'b1;
    end else if (accept) begin
      wv_d = 1'b0;
    end else if (complete) begin
      ov_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr_q  <= '1;
      cnt_q <= '0;
      wd_q  <= '0;
      wv_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      wd_q  <= wd_d;
      wv_q  <= wv_d;
      ov_q  <= ov_d;
    end
  end

  assign parallel_out = sr_q;
  assign bit_count    = cnt_q;
  assign word_data    = wd_q;
  assign word_valid   = wv_q;
  assign overrun      = ov_q;

`ifdef SD_STP_CRC16_EN
  logic [16*NUM_LANES-1:0] crc_q, crc_d;

  // Each lane runs its own CRC16-CCITT over every bit it carries; word
  // boundaries do not reset it, so it spans the whole data block.
  always_comb begin
    crc_d = crc_q;
    if (shift_enable) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        crc_d[16*i +: 16] = {crc_q[16*i +: 15], 1'b0} ^
                            ((crc_q[16*i+15] ^ serial_in[i]) ? 16'h1021 : 16'h0000);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;
`else
  assign crc_out = '0;
`endif

endmodule
